// File: rtl/dmem_bridge.sv
// Bridges the memory-stage load/store port onto a single-outstanding request/response bus,
// stalling the pipeline until the access completes or is aborted by the timeout.
module dmem_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic [31:0] o_dmem_rdata,
  output logic        o_stall,
  output logic        o_err,
  output logic        o_bus_req,
  input  logic        i_bus_gnt,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_mask,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] tmo_cnt;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic        we_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic        request;
  logic        tmo_hit;
  logic        addr_lsb_unused;

  // Byte offset is irrelevant on a word bus; lanes are selected by the mask.
  assign addr_lsb_unused = ^i_dmem_addr[1:0];

  assign request = i_dmem_ren | (i_dmem_wen & (|i_dmem_mask));
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (request) state_nxt = REQ;
      REQ: begin
        if (tmo_hit)        state_nxt = DONE;
        else if (i_bus_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (i_bus_rvalid || tmo_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A response arriving on the final allowed cycle takes priority over the abort.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      tmo_cnt <= 16'd0;
      addr_q  <= 30'd0;
      wdata_q <= 32'd0;
      mask_q  <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (request) begin
            addr_q  <= i_dmem_addr[31:2];
            wdata_q <= i_dmem_wdata;
            mask_q  <= i_dmem_mask;
            we_q    <= i_dmem_wen;
            tmo_cnt <= 16'd0;
            err_q   <= 1'b0;
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (tmo_hit) begin
            err_q   <= 1'b1;
            rdata_q <= 32'd0;
          end
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (i_bus_rvalid) begin
            if (!we_q) rdata_q <= i_bus_rdata;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            rdata_q <= 32'd0;
          end
        end
        DONE:    err_q <= 1'b0;
        default: err_q <= 1'b0;
      endcase
    end
  end

  assign o_stall      = !i_rst && (((state == IDLE) && request) || (state == REQ) || (state == WAIT));
  assign o_err        = (state == DONE) && err_q;
  assign o_bus_req    = (state == REQ);
  assign o_bus_we     = we_q;
  assign o_bus_addr   = {addr_q, 2'b00};
  assign o_bus_wdata  = wdata_q;
  assign o_bus_mask   = mask_q;
  assign o_dmem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized self-checking bench for dmem_bridge; expected timing and data are derived
// per access from the bus delays (cycle arithmetic), not from the design's state machine.
module tb_dmem_bridge;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dmem_addr;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mask;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        err;
  logic        bus_req;
  logic        bus_gnt;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_mask;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  dmem_bridge #(.TIMEOUT(TMO)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_dmem_addr  (dmem_addr),
    .i_dmem_ren   (dmem_ren),
    .i_dmem_wen   (dmem_wen),
    .i_dmem_wdata (dmem_wdata),
    .i_dmem_mask  (dmem_mask),
    .o_dmem_rdata (dmem_rdata),
    .o_stall      (stall),
    .o_err        (err),
    .o_bus_req    (bus_req),
    .i_bus_gnt    (bus_gnt),
    .o_bus_we     (bus_we),
    .o_bus_addr   (bus_addr),
    .o_bus_wdata  (bus_wdata),
    .o_bus_mask   (bus_mask),
    .i_bus_rvalid (bus_rvalid),
    .i_bus_rdata  (bus_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scrambleInputs();
    dmem_addr  = $urandom;
    dmem_wdata = $urandom;
    dmem_mask  = 4'($urandom);
    dmem_ren   = 1'($urandom);
    dmem_wen   = 1'($urandom);
  endtask

  // One complete access starting from an idle bridge; gd/rd are the extra cycles before
  // grant and before the response, no_resp withholds the response entirely.
  task automatic applyStimulus(input logic ren_v, input logic wen_v, input logic [31:0] addr_v,
                               input logic [31:0] wdata_v, input logic [3:0] mask_v,
                               input int gd, input int rd, input bit no_resp,
                               input bit scramble, input bit hold_done, input logic [31:0] resp);
    logic        is_req;
    logic [31:0] exp_addr;
    bit          timed_out;
    int          bus_cycles;
    is_req     = ren_v | (wen_v & (|mask_v));
    exp_addr   = {addr_v[31:2], 2'b00};
    timed_out  = no_resp || (gd + rd + 2 > TMO);
    bus_cycles = timed_out ? TMO : gd + rd + 2;

    dmem_ren = ren_v; dmem_wen = wen_v; dmem_addr = addr_v;
    dmem_wdata = wdata_v; dmem_mask = mask_v;
    bus_gnt = 1'b0; bus_rvalid = 1'($urandom); bus_rdata = $urandom;
    #1;
    checkOutput("idle_stall", 32'(stall), 32'(is_req));
    if (!is_req) begin
      step();
      checkOutput("noreq_bus_req", 32'(bus_req), 32'd0);
      checkOutput("noreq_stall", 32'(stall), 32'd0);
      checkOutput("noreq_rdata", dmem_rdata, model_rdata);
      return;
    end
    step();

    for (int c = 0; c < bus_cycles; c++) begin
      if (scramble) scrambleInputs();
      bus_gnt = (c == gd);
      if (c <= gd) bus_rvalid = 1'($urandom);
      else         bus_rvalid = !no_resp && (c == gd + 1 + rd);
      bus_rdata = (c > gd && bus_rvalid) ? resp : $urandom;
      #1;
      checkOutput("busy_stall", 32'(stall), 32'd1);
      checkOutput("busy_bus_req", 32'(bus_req), 32'(c <= gd));
      checkOutput("busy_err", 32'(err), 32'd0);
      checkOutput("busy_rdata", dmem_rdata, model_rdata);
      if (c <= gd) begin
        checkOutput("bus_addr", bus_addr, exp_addr);
        checkOutput("bus_we", 32'(bus_we), 32'(wen_v));
        checkOutput("bus_wdata", bus_wdata, wdata_v);
        checkOutput("bus_mask", 32'(bus_mask), 32'(mask_v));
      end
      step();
    end

    if (timed_out)  model_rdata = 32'd0;
    else if (!wen_v) model_rdata = resp;

    if (hold_done) begin
      dmem_ren = ren_v; dmem_wen = wen_v; dmem_addr = addr_v;
      dmem_wdata = wdata_v; dmem_mask = mask_v;
    end else begin
      dmem_ren = 1'b0; dmem_wen = 1'b0;
    end
    bus_gnt = 1'b0; bus_rvalid = 1'($urandom); bus_rdata = $urandom;
    #1;
    checkOutput("done_stall", 32'(stall), 32'd0);
    checkOutput("done_err", 32'(err), 32'(timed_out));
    checkOutput("done_rdata", dmem_rdata, model_rdata);
    checkOutput("done_bus_req", 32'(bus_req), 32'd0);
    step();
    bus_rvalid = 1'b0;
    #1;
    checkOutput("after_err", 32'(err), 32'd0);
    checkOutput("after_bus_req", 32'(bus_req), 32'd0);
    checkOutput("after_rdata", dmem_rdata, model_rdata);
  endtask

  initial begin
    logic [3:0] m;
    rst = 1'b1;
    dmem_ren = 1'b1; dmem_wen = 1'b0; dmem_addr = 32'h0000_0040;
    dmem_wdata = 32'hFFFF_FFFF; dmem_mask = 4'hF;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    model_rdata = 32'd0;
    #1;
    checkOutput("rst_stall", 32'(stall), 32'd0);
    step();
    step();
    checkOutput("rst_stall2", 32'(stall), 32'd0);
    checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
    checkOutput("rst_bus_we", 32'(bus_we), 32'd0);
    checkOutput("rst_bus_addr", bus_addr, 32'd0);
    checkOutput("rst_bus_wdata", bus_wdata, 32'd0);
    checkOutput("rst_bus_mask", 32'(bus_mask), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_rdata", dmem_rdata, 32'd0);
    rst = 1'b0;
    dmem_ren = 1'b0;

    // Minimum-latency load, delayed-grant store, empty-mask store, timeout, rvalid on last cycle
    applyStimulus(1'b1, 1'b0, 32'h0000_1006, 32'h0, 4'hF, 0, 0, 1'b0, 1'b0, 1'b0, 32'hA5A5_1234);
    applyStimulus(1'b0, 1'b1, 32'h0000_2000, 32'h1122_3344, 4'b1100, 4, 0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b1, 32'h0000_3000, 32'h5555_AAAA, 4'b0000, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    checkOutput("mask0_bus_req", 32'(bus_req), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 0, 1'b1, 1'b0, 1'b0, 32'h1357_9BDF);
    applyStimulus(1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'hF, 3, 3, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D);
    applyStimulus(1'b1, 1'b1, 32'h0000_0308, 32'h0BAD_0BAD, 4'b0011, 1, 2, 1'b0, 1'b1, 1'b0, 32'h7777_7777);

    // Load held across DONE is issued again only once the bridge is back in IDLE
    applyStimulus(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, 0, 1, 1'b0, 1'b0, 1'b1, 32'h2468_ACE0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, 0, 1, 1'b0, 1'b0, 1'b0, 32'h0F0F_0F0F);

    for (int i = 0; i < 60; i++) begin
      logic r, w;
      r = 1'($urandom);
      w = 1'($urandom);
      m = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      if (r && w && m == 4'h0) m = 4'hF;
      applyStimulus(r, w, $urandom, $urandom, m, $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 7) == 0), 1'b1, 1'b0, $urandom);
    end

    // Reset while waiting for the response; the late response must be ignored
    dmem_ren = 1'b1; dmem_wen = 1'b0; dmem_addr = 32'h0000_0800; dmem_mask = 4'hF;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    step();
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_stall", 32'(stall), 32'd0);
    step();
    rst = 1'b0;
    dmem_ren = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'h9999_9999;
    model_rdata = 32'd0;
    #1;
    checkOutput("midrst_stall2", 32'(stall), 32'd0);
    checkOutput("midrst_bus_req", 32'(bus_req), 32'd0);
    checkOutput("midrst_rdata", dmem_rdata, 32'd0);
    checkOutput("midrst_err", 32'(err), 32'd0);
    checkOutput("midrst_bus_addr", bus_addr, 32'd0);
    step();
    bus_rvalid = 1'b0;
    #1;
    checkOutput("late_rvalid_err", 32'(err), 32'd0);
    checkOutput("late_rvalid_rdata", dmem_rdata, 32'd0);
    checkOutput("late_rvalid_bus_req", 32'(bus_req), 32'd0);
    checkOutput("late_rvalid_stall", 32'(stall), 32'd0);

    applyStimulus(1'b1, 1'b0, 32'h0000_0C0C, 32'h0, 4'hF, 2, 0, 1'b0, 1'b0, 1'b0, 32'h4242_4242);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255; max bus cycles (REQ+WAIT) per access before forced abort, range 1..65535.
REQ-002 i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_dmem_addr  in  32  byte address from memory stage.
REQ-005 i_dmem_ren  in  1  load request.
REQ-006 i_dmem_wen  in  1  store request.
REQ-007 i_dmem_wdata  in  32  store data, pre-aligned to byte lanes.
REQ-008 i_dmem_mask  in  4  byte-lane enables.
REQ-009 o_dmem_rdata  out  32  load data returned to memory stage.
REQ-010 o_stall  out  1  hold pipeline; combinational.
REQ-011 o_err  out  1  one-cycle pulse: access aborted by timeout.
REQ-012 o_bus_req  out  1  bus request valid.
REQ-013 i_bus_gnt  in  1  bus accepts request this cycle when o_bus_req=1.
REQ-014 o_bus_we  out  1  1=write, 0=read.
REQ-015 o_bus_addr  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-016 o_bus_wdata  out  32  write data.
REQ-017 o_bus_mask  out  4  byte enables.
REQ-018 i_bus_rvalid  in  1  response (read data or write ack) valid.
REQ-019 i_bus_rdata  in  32  read data, valid with i_bus_rvalid.

Function
REQ-020 States IDLE, REQ, WAIT, DONE; one access in flight at most.
REQ-021 IDLE: request present = ren or (wen and mask!=0); on request, latch addr/wdata/mask/we into registers and go to REQ next edge.
REQ-022 ren and wen both high: treat as write (wen priority), latched mask used.
REQ-023 wen with mask=4'b0000 and ren=0: no bus transaction, no stall, remain IDLE.
REQ-024 o_stall=1 in IDLE when a request is present, and in REQ and WAIT; o_stall=0 in DONE and idle-with-no-request.
REQ-025 REQ: o_bus_req=1 with latched fields stable; on i_bus_gnt=1 go to WAIT; i_bus_rvalid in REQ ignored.
REQ-026 WAIT: o_bus_req=0; on i_bus_rvalid=1 go to DONE; on read capture i_bus_rdata into o_dmem_rdata; writes leave o_dmem_rdata unchanged.
REQ-027 DONE: exactly one cycle, o_stall=0, pipeline advances; always returns to IDLE without sampling inputs (prevents reissue of held request).
REQ-028 Minimum load latency: request cycle + REQ + WAIT + DONE = stall for 3 cycles when gnt and rvalid each come first cycle possible (gnt in REQ cycle, rvalid the following cycle).
REQ-029 Timeout counter 16 bits, cleared on IDLE->REQ, increments each cycle in REQ or WAIT; on reaching TIMEOUT go to DONE, pulse o_err in DONE, o_dmem_rdata forced to 32'h0000_0000.
REQ-030 Timeout and i_bus_rvalid in same cycle: rvalid wins, no o_err.
REQ-031 o_bus_we/addr/wdata/mask driven from latched registers only, never directly from pipeline inputs.
REQ-032 o_dmem_rdata holds its last value in all other cycles.

Reset
REQ-033 i_rst=1 at an edge: state=IDLE, counter=0, o_dmem_rdata=0, latched regs=0; outputs after edge: o_bus_req=0, o_bus_we=0, o_bus_addr=0, o_bus_wdata=0, o_bus_mask=0, o_err=0.
REQ-034 While i_rst=1, o_stall=0 regardless of request inputs.
REQ-035 Reset mid-access (REQ or WAIT): access abandoned, no o_err; a late i_bus_rvalid arriving in IDLE is ignored.

Verification
REQ-036 Load addr 0x0000_1006, gnt same cycle as REQ, rvalid next cycle with 0xA5A5_1234 -> o_bus_addr=0x0000_1004, o_stall high 3 cycles, o_dmem_rdata=0xA5A5_1234 in DONE.
REQ-037 Store wdata 0x1122_3344 mask 4'b1100, gnt delayed 4 cycles -> o_bus_req held 5 cycles with stable fields, o_bus_we=1, o_dmem_rdata unchanged.
REQ-038 Store with mask 4'b0000 -> o_bus_req never asserted, o_stall=0.
REQ-039 TIMEOUT=8, load, gnt given, rvalid never -> DONE after 8 bus cycles, o_err pulses once, o_dmem_rdata=0.
REQ-040 Reset asserted in WAIT, rvalid next cycle -> state IDLE, o_dmem_rdata=0, no o_err, no stall.
REQ-041 Load held across DONE (inputs unchanged) -> exactly one bus transaction, then new request accepted next IDLE cycle.
